// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard unit: divider-sequencer states and ALU
// forward-select codes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Divider start/ready sequencer. freeze covers the start cycle plus every
// cycle waiting for the result; DONE blocks the same divide from restarting.
import hazard_ctrl_pkg::*;

module hazard_ctrl_div_seq (
  input  logic clk,
  input  logic rst,
  input  logic div_e,
  input  logic div_ready,
  output logic div_start,
  output logic div_busy,
  output logic freeze
);

  div_state_t state_reg;
  div_state_t state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    div_busy   = 1'b0;
    freeze     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (div_e) begin
          div_start  = 1'b1;
          freeze     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        div_busy = 1'b1;
        freeze   = 1'b1;
        if (div_ready) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch stalls,
// flushes and divider sequencing. Optional stall counter: HAZARD_STALL_CNT_EN.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int REGW  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            divE,
  input  logic            div_ready,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushE,
  output logic            flushM,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            div_start,
  output logic            div_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (REGW < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl: REGW and CNT_W must be positive");
  end

  logic [REGW-1:0] src_e [2];
  logic [REGW-1:0] src_d [2];
  logic [1:0]      fwd_e [2];
  logic            fwd_d [2];

  assign src_e[0] = rsE;
  assign src_e[1] = rtE;
  assign src_d[0] = rsD;
  assign src_d[1] = rtD;

  // Register 0 is hardwired, so it never matches a producer; M beats W.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      fwd_e[gi] = FWD_RF;
      if (src_e[gi] != '0 && regwriteM && src_e[gi] == writeregM) begin
        fwd_e[gi] = FWD_M;
      end else if (src_e[gi] != '0 && regwriteW && src_e[gi] == writeregW) begin
        fwd_e[gi] = FWD_W;
      end
    end
    assign fwd_d[gi] = (src_d[gi] != '0) && regwriteM && (src_d[gi] == writeregM);
  end

  logic lwstall;
  logic branchstall;
  logic hazard_stall;

  assign lwstall     = memtoregE && (rtE == rsD || rtE == rtD);
  assign branchstall = branchD &&
                       ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                        (memtoregM && (writeregM == rsD || writeregM == rtD)));
  assign hazard_stall = lwstall || branchstall;

  logic seq_start;
  logic seq_busy;
  logic freeze;

  hazard_ctrl_div_seq u_div_seq (
    .clk       (clk),
    .rst       (rst),
    .div_e     (divE),
    .div_ready (div_ready),
    .div_start (seq_start),
    .div_busy  (seq_busy),
    .freeze    (freeze)
  );

  // A divider freeze overrides and masks the ordinary hazard stalls;
  // every output is forced low combinationally while reset is held.
  always_comb begin
    stallF    = rst && (freeze || hazard_stall);
    stallD    = rst && (freeze || hazard_stall);
    stallE    = rst && freeze;
    flushE    = rst && !freeze && hazard_stall;
    flushM    = rst && freeze;
    forwardaD = rst && fwd_d[0];
    forwardbD = rst && fwd_d[1];
    forwardaE = rst ? fwd_e[0] : FWD_RF;
    forwardbE = rst ? fwd_e[1] : FWD_RF;
    div_start = rst && seq_start;
    div_busy  = rst && seq_busy;
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (stallF && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level reference model.
`timescale 1ns/1ps

module tb_hazard_ctrl;

  localparam int REGW     = 5;
  localparam int TB_CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic            regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic            branchD, divE, div_ready;
  logic            stallF, stallD, stallE, flushE, flushM;
  logic            forwardaD, forwardbD;
  logic [1:0]      forwardaE, forwardbE;
  logic            div_start, div_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REGW(REGW), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .divE(divE), .div_ready(div_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .div_start(div_start), .div_busy(div_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0; divE = 0; div_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Outputs packed as {stallF,stallD,stallE,flushE,flushM,fwdaD,fwdbD,fwdaE,fwdbE,start,busy}
  function automatic logic [12:0] outs();
    return {stallF, stallD, stallE, flushE, flushM, forwardaD, forwardbD,
            forwardaE, forwardbE, div_start, div_busy};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    rsE = 5; writeregM = 5; regwriteM = 1; rsD = 5;
    memtoregE = 1; rtE = 5; divE = 1;
    #1;
    total++;
    if (outs() !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b need %b", outs(), 13'd0);
    end
`ifdef HAZARD_STALL_CNT_EN
    total++;
    if (stall_cnt !== '0) begin
      bad++;
      $display("FAIL reset_stall_cnt: got %0d need 0", stall_cnt);
    end
`endif
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 13'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got %b need %b", outs(), 13'd0);
    end
    $display("test_reset done");
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    writeregM = 5; regwriteM = 1; rsE = 5; writeregW = 5; regwriteW = 1;
    #1;
    total++;
    if (forwardaE !== 2'b10) begin
      bad++;
      $display("FAIL fwd_m_priority: got %b need 10", forwardaE);
    end
    regwriteM = 0;
    #1;
    total++;
    if (forwardaE !== 2'b01) begin
      bad++;
      $display("FAIL fwd_w: got %b need 01", forwardaE);
    end
    rsE = 0; writeregW = 0; writeregM = 0; regwriteM = 1;
    #1;
    total++;
    if (forwardaE !== 2'b00) begin
      bad++;
      $display("FAIL fwd_r0: got %b need 00", forwardaE);
    end
    rtE = 7; writeregM = 7; rtD = 7; rsD = 0;
    #1;
    total++;
    if ({forwardbE, forwardbD, forwardaD} !== 4'b1010) begin
      bad++;
      $display("FAIL fwd_b_paths: got %b need 1010", {forwardbE, forwardbD, forwardaD});
    end
    $display("test_forwarding done");
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    memtoregE = 1; rtE = 8; rsD = 8; rtD = 2;
    #1;
    total++;
    if ({stallF, stallD, flushE, stallE, flushM} !== 5'b11100) begin
      bad++;
      $display("FAIL load_use_stall: got %b need 11100", {stallF, stallD, flushE, stallE, flushM});
    end
    @(negedge clk);
    memtoregE = 0;
    #1;
    total++;
    if ({stallF, stallD, flushE} !== 3'b000) begin
      bad++;
      $display("FAIL load_use_release: got %b need 000", {stallF, stallD, flushE});
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; rsD = 1;
    #1;
    total++;
    if ({stallF, stallD, flushE} !== 3'b111) begin
      bad++;
      $display("FAIL branch_e_stall: got %b need 111", {stallF, stallD, flushE});
    end
    regwriteE = 0; memtoregM = 1; writeregM = 1;
    #1;
    total++;
    if ({stallF, stallD, flushE} !== 3'b111) begin
      bad++;
      $display("FAIL branch_m_load_stall: got %b need 111", {stallF, stallD, flushE});
    end
    branchD = 0;
    #1;
    total++;
    if ({stallF, stallD, flushE} !== 3'b000) begin
      bad++;
      $display("FAIL branch_none: got %b need 000", {stallF, stallD, flushE});
    end
    $display("test_branch done");
  endtask

  // 4-cycle divide, then a back-to-back 1-cycle divide; load-use held
  // throughout to confirm the freeze masks it.
  task automatic test_divide();
    int frz = 0;
    int busy_cyc = 0;
    @(negedge clk);
    clear_inputs();
    divE = 1; memtoregE = 1; rtE = 4; rsD = 4;
    #1;
    total++;
    if (outs() !== 13'b11101_00_0000_10) begin
      bad++;
      $display("FAIL div_start_cycle: got %b need %b", outs(), 13'b11101_00_0000_10);
    end
    frz += stallE;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      div_ready = (c == 4);
      #1;
      frz += stallE;
      busy_cyc += div_busy;
      total++;
      if ({stallF, stallD, stallE, flushE, flushM, div_start, div_busy} !== 7'b1110101) begin
        bad++;
        $display("FAIL div_run_%0d: got %b need 1110101", c,
                 {stallF, stallD, stallE, flushE, flushM, div_start, div_busy});
      end
    end
    @(negedge clk);
    div_ready = 0; memtoregE = 0;
    #1;
    total++;
    if (outs() !== 13'd0) begin
      bad++;
      $display("FAIL div_done_cycle: got %b need %b", outs(), 13'd0);
    end
    total++;
    if (frz !== 5 || busy_cyc !== 4) begin
      bad++;
      $display("FAIL div_lengths: got freeze=%0d busy=%0d need freeze=5 busy=4", frz, busy_cyc);
    end
    @(negedge clk);
    #1;
    total++;
    if ({div_start, stallE} !== 2'b11) begin
      bad++;
      $display("FAIL div_back_to_back: got %b need 11", {div_start, stallE});
    end
    @(negedge clk);
    div_ready = 1;
    #1;
    total++;
    if ({div_busy, stallE} !== 2'b11) begin
      bad++;
      $display("FAIL div_min_latency_run: got %b need 11", {div_busy, stallE});
    end
    @(negedge clk);
    div_ready = 0;
    #1;
    total++;
    if ({div_busy, stallE, div_start} !== 3'b000) begin
      bad++;
      $display("FAIL div_min_latency_done: got %b need 000", {div_busy, stallE, div_start});
    end
    @(negedge clk);
    divE = 0;
    $display("test_divide done");
  endtask

  task automatic test_reset_mid_divide();
    @(negedge clk);
    clear_inputs();
    divE = 1;
    @(negedge clk);
    rsE = 6; writeregM = 6; regwriteM = 1;
    #1;
    total++;
    if (div_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_div_busy: got %b need 1", div_busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (outs() !== 13'd0) begin
      bad++;
      $display("FAIL mid_div_reset: got %b need %b", outs(), 13'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    div_ready = 1;
    #1;
    total++;
    if (outs() !== 13'd0) begin
      bad++;
      $display("FAIL stray_ready: got %b need %b", outs(), 13'd0);
    end
    @(negedge clk);
    div_ready = 0;
    #1;
    total++;
    if ({stallE, div_busy} !== 2'b00) begin
      bad++;
      $display("FAIL stray_ready_after: got %b need 00", {stallE, div_busy});
    end
    $display("test_reset_mid_divide done");
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      memtoregE = 1; rtE = 9; rtD = 9;
    end
    @(negedge clk);
    clear_inputs();
    divE = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      div_ready = (c == 4);
    end
    @(negedge clk);
    div_ready = 0;
    divE = 0;
    #1;
    total++;
    if (stall_cnt !== 8) begin
      bad++;
      $display("FAIL stall_cnt_8: got %0d need 8", stall_cnt);
    end
    @(negedge clk);
    memtoregE = 1; rtE = 2; rsD = 2;
    repeat (12) @(negedge clk);
    #1;
    total++;
    if (stall_cnt !== {TB_CNT_W{1'b1}}) begin
      bad++;
      $display("FAIL stall_cnt_saturate: got %0d need %0d", stall_cnt, {TB_CNT_W{1'b1}});
    end
    $display("test_stall_cnt done");
  endtask
`endif

  // Reference model: per-cycle rules straight from the hazard definitions.
  function automatic logic [1:0] ref_fwd_e(logic [REGW-1:0] s);
    if (s != 0 && regwriteM && s == writeregM) return 2'b10;
    if (s != 0 && regwriteW && s == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    bit divider_active = 0;
    bit cooldown = 0;
    int cnt = 0;
    int cnt_max = (1 << TB_CNT_W) - 1;
    int errs_before = bad;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      logic lw, br, hz, frz, start;
      logic [12:0] exp_o;
      @(negedge clk);
      rsD = REGW'($urandom_range(0, 3)); rtD = REGW'($urandom_range(0, 3));
      rsE = REGW'($urandom_range(0, 3)); rtE = REGW'($urandom_range(0, 3));
      writeregE = REGW'($urandom_range(0, 3));
      writeregM = REGW'($urandom_range(0, 3));
      writeregW = REGW'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
      branchD = 1'($urandom);
      divE = ($urandom_range(0, 4) == 0);
      div_ready = ($urandom_range(0, 2) == 0);
      #1;
      lw = memtoregE && (rtE == rsD || rtE == rtD);
      br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                       (memtoregM && (writeregM == rsD || writeregM == rtD)));
      hz = lw || br;
      start = !divider_active && !cooldown && divE;
      frz = divider_active || start;
      exp_o = {frz || hz, frz || hz, frz, !frz && hz, frz,
               (rsD != 0 && regwriteM && rsD == writeregM),
               (rtD != 0 && regwriteM && rtD == writeregM),
               ref_fwd_e(rsE), ref_fwd_e(rtE), start, divider_active};
      total++;
      if (outs() !== exp_o) begin
        bad++;
        $display("FAIL random_cycle_%0d: got %b need %b", n, outs(), exp_o);
      end
      @(posedge clk);
      if ((frz || hz) && cnt < cnt_max) cnt++;
      if (divider_active) begin
        if (div_ready) begin
          divider_active = 0;
          cooldown = 1;
        end
      end else if (cooldown) begin
        cooldown = 0;
      end else if (divE) begin
        divider_active = 1;
      end
    end
`ifdef HAZARD_STALL_CNT_EN
    @(negedge clk);
    #1;
    total++;
    if (stall_cnt !== TB_CNT_W'(cnt)) begin
      bad++;
      $display("FAIL random_stall_cnt: got %0d need %0d", stall_cnt, cnt);
    end
`endif
    $display("test_random done: cycles=400 errors=%0d", bad - errs_before);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_divide();
    test_reset_mid_divide();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing unit for the 5-stage MIPS pipeline. It sits beside the stage controller and datapath.
- Generates forwarding selects, load-use and branch-in-decode stalls, and pipeline flushes.
- Sequences the multicycle divider through a start/ready handshake, freezing F/D/E while the divider runs.

Parameters:
- REGW, 5, register-index width.
- CNT_W, 32, stall-counter width (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rsD, rtD  in  REGW  decode source registers.
- rsE, rtE  in  REGW  execute source registers.
- writeregE, writeregM, writeregW  in  REGW  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1  write-enable per stage.
- memtoregE, memtoregM  in  1  load in E / M.
- branchD  in  1  branch in decode.
- divE  in  1  divide instruction in E.
- div_ready  in  1  divider result valid, 1-cycle pulse.
- stallF, stallD, stallE  out  1  hold the PC / D / E registers.
- flushE, flushM  out  1  insert a bubble into E / M.
- forwardaD, forwardbD  out  1  decode compare-operand bypass from M.
- forwardaE, forwardbE  out  2  ALU operand select: 00 regfile, 01 W, 10 M.
- div_start  out  1  divider start, 1-cycle pulse.
- div_busy  out  1  divider sequence in progress.

Behaviour:
- Reset: while rst=0, FSM goes to IDLE and every output is forced to 0. A reset during RUN aborts the division; the divider shares rst.
- Forwarding (combinational):
  - forwardaE=10 if rsE!=0 & regwriteM & rsE==writeregM.
  - Otherwise forwardaE=01 if rsE!=0 & regwriteW & rsE==writeregW.
  - Otherwise 00. M has priority over W.
  - forwardbE: same rules using rtE.
  - forwardaD = rsD!=0 & regwriteM & rsD==writeregM. forwardbD: same using rtD.
- Stall conditions:
  - lwstall = memtoregE & (rtE==rsD | rtE==rtD).
  - branchstall = branchD & [ (regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD)) ].
- FSM states: IDLE, RUN, DONE.
  - IDLE: divE=1 -> div_start=1 this cycle, next state RUN.
  - RUN: div_busy=1. div_ready=1 -> DONE; otherwise stay in RUN.
  - DONE: lasts one cycle, returns to IDLE. Prevents the same divide, still in E, from retriggering.
  - div_ready outside RUN is ignored.
- Output priority:
  - RUN, and IDLE with divE=1: stallF=stallD=stallE=1, flushM=1, flushE=0. lwstall and branchstall are masked.
  - DONE and other cycles: stallF=stallD=lwstall|branchstall, flushE=lwstall|branchstall, stallE=0, flushM=0.
- Divider latency: minimum 1 cycle. Pipeline frozen for (cycles until div_ready)+1. The divide leaves E on the clock edge ending DONE.
- Back-to-back divides: a second divE seen in the IDLE cycle after DONE starts a new sequence.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cnt [CNT_W-1:0].
  - Increments each cycle stallF=1.
  - Saturates at all-ones.
  - Reset to 0 by rst.
- Undefined: port and counter are absent. Function is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and forward-select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
- One natural sub-module, div_seq: contains the FSM and handshake, and exports div_start, div_busy and a freeze flag.
- Forwarding and stall logic stay in the top level.

Test Plan:
- RAW forwarding: writeregM=5, regwriteM=1, rsE=5 -> forwardaE=10. Same with writeregW=5 and regwriteM=0 -> 01. rsE=0 -> 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for exactly 1 cycle, then 0 once memtoregE=0.
- Branch hazard: branchD=1, regwriteE=1, writeregE=rtD=3 -> stallF=stallD=flushE=1.
- Divide: divE=1 in IDLE -> div_start pulse. div_ready 4 cycles later -> stallF/D/E=1 and flushM=1 for 5 cycles total, div_busy=1 for 4 cycles, then one DONE cycle with no stall.
- Reset mid-divide: rst=0 during RUN -> all outputs 0 immediately. After release, state is IDLE and a stray div_ready is ignored.
- HAZARD_STALL_CNT_EN: 3 load-use stalls plus a 5-cycle divide freeze -> stall_cnt=8. A counter preloaded near max saturates at all-ones.
